// File: rtl/frame_downsampler.sv
// frame_downsampler: crops a 2*OUT_W x 2*OUT_H window from the captured RGB565
// stream, box-averages each 2x2 block and emits 8-bit RGB with a linear
// frame-buffer address. Framing follows camera vsync.
// Optional build macro FRAME_DOWNSAMPLER_GRAY_EN adds a registered o_gray luma output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_SYNC | after reset; pixels ignored until vsync goes high
// IN_SYNC   | vsync high; waiting for its falling edge to start a frame
// ACTIVE    | frame in progress; in-crop pixels are processed
// DONE      | last output pixel emitted; pixels ignored until next vsync
module frame_downsampler #(
   parameter int CROP_X0 = 96,
   parameter int CROP_Y0 = 16,
   parameter int OUT_W   = 224,
   parameter int OUT_H   = 224,
   parameter int ADDR_W  = 16
) (
   input  logic              i_pclk,
   input  logic              i_reset,
   input  logic              i_vsync,
   input  logic [15:0]       i_pixelIn,
   input  logic              i_pixelValid,
   input  logic [9:0]        i_xIndex,
   input  logic [9:0]        i_yIndex,
   output logic              o_valid,
   output logic [7:0]        o_r,
   output logic [7:0]        o_g,
   output logic [7:0]        o_b,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_frameDone,
   output logic              o_busy
`ifdef FRAME_DOWNSAMPLER_GRAY_EN
   ,
   output logic [7:0]        o_gray
`endif
);

   // 12 signed bits cover a 10-bit index minus any sane crop offset
   localparam int CW    = 12;
   localparam int LB_AW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      IN_SYNC   = 2'd1,
      ACTIVE    = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic signed [CW-1:0] cx, cy;
   logic                 in_crop;
   logic                 cx_odd, cy_odd;
   logic [LB_AW-1:0]     lb_idx;
   logic [CW-2:0]        oy;
   logic                 last_pix;
   logic [ADDR_W-1:0]    addr_calc;

   logic [4:0]  pix_r5, pix_b5;
   logic [5:0]  pix_g6;
   logic [7:0]  pix_r8, pix_g8, pix_b8;
   logic [8:0]  hsum_r, hsum_g, hsum_b;
   logic [9:0]  vsum_r, vsum_g, vsum_b;
   logic [7:0]  avg_r, avg_g, avg_b;

   // held even-column pixel, {R8,G8,B8}
   logic [23:0] hold_q, hold_d;

   // line buffer of horizontal pair sums, {R9,G9,B9}
   logic [26:0] lb [OUT_W];
   logic [26:0] lb_rd_q;
   logic        lb_we, lb_re;

   logic              valid_q, valid_d;
   logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              frame_done_q, frame_done_d;

`ifdef FRAME_DOWNSAMPLER_GRAY_EN
   logic [15:0] gray_sum;
   logic [7:0]  gray_q, gray_d;
`endif

   // crop-relative coordinates; the capture stage has already advanced the column index
   always_comb begin
      cx       = $signed({2'b00, i_xIndex}) - $signed(CW'(CROP_X0 + 1));
      cy       = $signed({2'b00, i_yIndex}) - $signed(CW'(CROP_Y0));
      in_crop  = !cx[CW-1] && !cy[CW-1] &&
                 (cx < $signed(CW'(2 * OUT_W))) && (cy < $signed(CW'(2 * OUT_H)));
      cx_odd   = cx[0];
      cy_odd   = cy[0];
      lb_idx   = cx[LB_AW:1];
      oy       = cy[CW-1:1];
      last_pix = (lb_idx == LB_AW'(OUT_W - 1)) && (oy == (CW-1)'(OUT_H - 1));
      addr_calc = ADDR_W'(32'(oy) * 32'(OUT_W) + 32'(lb_idx));
   end

   // channel expansion to 8 bits and the horizontal / vertical pair sums
   always_comb begin
      pix_r5 = i_pixelIn[15:11];
      pix_g6 = i_pixelIn[10:5];
      pix_b5 = i_pixelIn[4:0];
      pix_r8 = {pix_r5, pix_r5[4:2]};
      pix_g8 = {pix_g6, pix_g6[5:4]};
      pix_b8 = {pix_b5, pix_b5[4:2]};
      hsum_r = {1'b0, hold_q[23:16]} + {1'b0, pix_r8};
      hsum_g = {1'b0, hold_q[15:8]}  + {1'b0, pix_g8};
      hsum_b = {1'b0, hold_q[7:0]}   + {1'b0, pix_b8};
      vsum_r = {1'b0, lb_rd_q[26:18]} + {1'b0, hsum_r};
      vsum_g = {1'b0, lb_rd_q[17:9]}  + {1'b0, hsum_g};
      vsum_b = {1'b0, lb_rd_q[8:0]}   + {1'b0, hsum_b};
      avg_r  = 8'(vsum_r >> 2);
      avg_g  = 8'(vsum_g >> 2);
      avg_b  = 8'(vsum_b >> 2);
`ifdef FRAME_DOWNSAMPLER_GRAY_EN
      gray_sum = {8'd0, avg_r} * 16'd77 + {8'd0, avg_g} * 16'd150 + {8'd0, avg_b} * 16'd29;
`endif
   end

   // framing FSM plus the per-pixel datapath control; vsync always beats a pixel strobe
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      valid_d      = 1'b0;
      frame_done_d = 1'b0;
      r_d          = r_q;
      g_d          = g_q;
      b_d          = b_q;
      addr_d       = addr_q;
      lb_we        = 1'b0;
      lb_re        = 1'b0;
`ifdef FRAME_DOWNSAMPLER_GRAY_EN
      gray_d       = gray_q;
`endif
      case (state_q)
         WAIT_SYNC: begin
            if (i_vsync) state_d = IN_SYNC;
         end
         IN_SYNC: begin
            if (!i_vsync) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (i_vsync) begin
               state_d = IN_SYNC;
               hold_d  = '0;
            end else if (i_pixelValid && in_crop) begin
               if (!cx_odd) begin
                  hold_d = {pix_r8, pix_g8, pix_b8};
                  lb_re  = cy_odd;
               end else if (!cy_odd) begin
                  lb_we = 1'b1;
               end else begin
                  valid_d = 1'b1;
                  r_d     = avg_r;
                  g_d     = avg_g;
                  b_d     = avg_b;
                  addr_d  = addr_calc;
`ifdef FRAME_DOWNSAMPLER_GRAY_EN
                  gray_d  = 8'(gray_sum >> 8);
`endif
                  if (last_pix) begin
                     frame_done_d = 1'b1;
                     state_d      = DONE;
                  end
               end
            end
         end
         DONE: begin
            if (i_vsync) state_d = IN_SYNC;
         end
         default: state_d = WAIT_SYNC;
      endcase
   end

   // state and output registers with synchronous active-low reset
   always_ff @(posedge i_pclk) begin
      if (!i_reset) begin
         state_q      <= WAIT_SYNC;
         hold_q       <= '0;
         valid_q      <= 1'b0;
         r_q          <= '0;
         g_q          <= '0;
         b_q          <= '0;
         addr_q       <= '0;
         frame_done_q <= 1'b0;
`ifdef FRAME_DOWNSAMPLER_GRAY_EN
         gray_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         valid_q      <= valid_d;
         r_q          <= r_d;
         g_q          <= g_d;
         b_q          <= b_d;
         addr_q       <= addr_d;
         frame_done_q <= frame_done_d;
`ifdef FRAME_DOWNSAMPLER_GRAY_EN
         gray_q       <= gray_d;
`endif
      end
   end

   // single-port line buffer with registered read; contents need no reset
   always_ff @(posedge i_pclk) begin
      if (lb_we) lb[lb_idx] <= {hsum_r, hsum_g, hsum_b};
      if (lb_re) lb_rd_q    <= lb[lb_idx];
   end

   assign o_valid     = valid_q;
   assign o_r         = r_q;
   assign o_g         = g_q;
   assign o_b         = b_q;
   assign o_addr      = addr_q;
   assign o_frameDone = frame_done_q;
   assign o_busy      = (state_q == ACTIVE);
`ifdef FRAME_DOWNSAMPLER_GRAY_EN
   assign o_gray      = gray_q;
`endif

endmodule

// File: tb/tb_frame_downsampler.sv
// Bench for frame_downsampler: reduced geometry so whole frames stay short.
// Stimulus pushes expected output blocks, computed from a stored frame image,
// into a scoreboard; a negedge monitor pops and compares on every o_valid.
module tb_frame_downsampler;

   localparam int CROP_X0 = 4;
   localparam int CROP_Y0 = 2;
   localparam int OUT_W   = 6;
   localparam int OUT_H   = 4;
   localparam int ADDR_W  = 8;
   localparam int NCOLS   = CROP_X0 + 2 * OUT_W + 2;
   localparam int NROWS   = CROP_Y0 + 2 * OUT_H + 1;

   logic              clk;
   logic              i_reset;
   logic              i_vsync;
   logic [15:0]       i_pixelIn;
   logic              i_pixelValid;
   logic [9:0]        i_xIndex;
   logic [9:0]        i_yIndex;
   logic              o_valid;
   logic [7:0]        o_r, o_g, o_b;
   logic [ADDR_W-1:0] o_addr;
   logic              o_frameDone;
   logic              o_busy;
`ifdef FRAME_DOWNSAMPLER_GRAY_EN
   logic [7:0]        o_gray;
`endif

   frame_downsampler #(
      .CROP_X0(CROP_X0), .CROP_Y0(CROP_Y0), .OUT_W(OUT_W), .OUT_H(OUT_H), .ADDR_W(ADDR_W)
   ) dut (
      .i_pclk(clk),
      .i_reset(i_reset),
      .i_vsync(i_vsync),
      .i_pixelIn(i_pixelIn),
      .i_pixelValid(i_pixelValid),
      .i_xIndex(i_xIndex),
      .i_yIndex(i_yIndex),
      .o_valid(o_valid),
      .o_r(o_r),
      .o_g(o_g),
      .o_b(o_b),
      .o_addr(o_addr),
      .o_frameDone(o_frameDone),
      .o_busy(o_busy)
`ifdef FRAME_DOWNSAMPLER_GRAY_EN
      ,
      .o_gray(o_gray)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int r;
      int g;
      int b;
      int gray;
      int done;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   valid_seen = 0;
   int   done_seen = 0;

   logic [15:0] frame [NROWS][NCOLS];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // 5/6-bit colour scaled to 8 bits by replicating its top bits into the low bits
   function automatic int ch8(input logic [15:0] p, input int c);
      int v;
      if (c == 0) begin
         v = int'(p[15:11]);
         return (v << 3) | (v >> 2);
      end else if (c == 1) begin
         v = int'(p[10:5]);
         return (v << 2) | (v >> 4);
      end else begin
         v = int'(p[4:0]);
         return (v << 3) | (v >> 2);
      end
   endfunction

   task automatic push_block(input int ox, input int oy);
      exp_t e;
      int   avg[3];
      int   x0, y0;
      x0 = CROP_X0 + 2 * ox;
      y0 = CROP_Y0 + 2 * oy;
      for (int c = 0; c < 3; c++)
         avg[c] = (ch8(frame[y0][x0], c) + ch8(frame[y0][x0+1], c) +
                   ch8(frame[y0+1][x0], c) + ch8(frame[y0+1][x0+1], c)) / 4;
      e.addr = oy * OUT_W + ox;
      e.r    = avg[0];
      e.g    = avg[1];
      e.b    = avg[2];
      e.gray = (77 * avg[0] + 150 * avg[1] + 29 * avg[2]) / 256;
      e.done = (ox == OUT_W - 1 && oy == OUT_H - 1) ? 1 : 0;
      sb.push_back(e);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin : mon
      exp_t e;
      if (o_frameDone) chk("done_with_valid", int'(o_valid), 1);
      if (o_valid) begin
         valid_seen++;
         if (o_frameDone) done_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got addr %0d expected no output", o_addr);
         end else begin
            e = sb.pop_front();
            chk("addr", int'(o_addr), e.addr);
            chk("r", int'(o_r), e.r);
            chk("g", int'(o_g), e.g);
            chk("b", int'(o_b), e.b);
            chk("frame_done", int'(o_frameDone), e.done);
`ifdef FRAME_DOWNSAMPLER_GRAY_EN
            chk("gray", int'(o_gray), e.gray);
`endif
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_pix(input int row, input int col, input logic [15:0] p,
                           input bit vs, input bit exp_valid);
      @(negedge clk);
      i_pixelIn    = p;
      i_xIndex     = 10'(col + 1);
      i_yIndex     = 10'(row);
      i_pixelValid = 1'b1;
      i_vsync      = vs;
      @(posedge clk);
      #1;
      chk("valid_latency", int'(o_valid), int'(exp_valid));
      @(negedge clk);
      i_pixelValid = 1'b0;
      @(posedge clk);
   endtask

   // mode 0 random, 1 crop FFFF, 2 crop 0000 / outside FFFF, 3 crop F800
   task automatic fill(input int mode);
      bit inc;
      for (int r = 0; r < NROWS; r++)
         for (int c = 0; c < NCOLS; c++) begin
            inc = (c >= CROP_X0 && c < CROP_X0 + 2 * OUT_W &&
                   r >= CROP_Y0 && r < CROP_Y0 + 2 * OUT_H);
            case (mode)
               1:       frame[r][c] = inc ? 16'hFFFF : 16'h0000;
               2:       frame[r][c] = inc ? 16'h0000 : 16'hFFFF;
               3:       frame[r][c] = inc ? 16'hF800 : 16'h0000;
               default: frame[r][c] = 16'($urandom);
            endcase
         end
   endtask

   task automatic stream(input bit expect_out, input int stop_row, input int stop_col,
                         input bit vs_at_stop);
      int cx, cy;
      bit blk;
      for (int r = 0; r < NROWS; r++)
         for (int c = 0; c < NCOLS; c++) begin
            if (r == stop_row && c == stop_col) begin
               if (vs_at_stop) send_pix(r, c, frame[r][c], 1'b1, 1'b0);
               return;
            end
            cx  = c - CROP_X0;
            cy  = r - CROP_Y0;
            blk = expect_out && cx >= 0 && cx < 2 * OUT_W && cy >= 0 && cy < 2 * OUT_H &&
                  (cx % 2 == 1) && (cy % 2 == 1);
            if (blk) push_block(cx / 2, cy / 2);
            send_pix(r, c, frame[r][c], 1'b0, blk);
         end
   endtask

   task automatic vsync_pulse();
      @(negedge clk);
      i_vsync = 1'b1;
      repeat (3) @(negedge clk);
      i_vsync = 1'b0;
      repeat (2) @(negedge clk);
      chk("busy_after_vsync", int'(o_busy), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_r", int'(o_r), 0);
      chk("rst_g", int'(o_g), 0);
      chk("rst_b", int'(o_b), 0);
      chk("rst_addr", int'(o_addr), 0);
      chk("rst_done", int'(o_frameDone), 0);
      chk("rst_busy", int'(o_busy), 0);
`ifdef FRAME_DOWNSAMPLER_GRAY_EN
      chk("rst_gray", int'(o_gray), 0);
`endif
      i_reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic full_frame(input int mode, input string name);
      int d0, v0;
      fill(mode);
      vsync_pulse();
      d0 = done_seen;
      v0 = valid_seen;
      stream(1'b1, NROWS, 0, 1'b0);
      repeat (4) @(negedge clk);
      chk({name, "_done_count"}, done_seen - d0, 1);
      chk({name, "_valid_count"}, valid_seen - v0, OUT_W * OUT_H);
      chk({name, "_busy_after_done"}, int'(o_busy), 0);
   endtask

   initial begin
      int d0, v0;
      i_reset      = 1'b1;
      i_vsync      = 1'b0;
      i_pixelIn    = '0;
      i_pixelValid = 1'b0;
      i_xIndex     = '0;
      i_yIndex     = '0;

      do_reset();

      // pixels before any vsync are ignored
      fill(0);
      v0 = valid_seen;
      stream(1'b0, NROWS, 0, 1'b0);
      chk("no_output_before_vsync", valid_seen - v0, 0);

      full_frame(1, "white");

      // known 2x2 block at the crop origin, random elsewhere
      do_reset();
      fill(0);
      frame[CROP_Y0][CROP_X0]       = 16'hF800;
      frame[CROP_Y0][CROP_X0+1]     = 16'h0000;
      frame[CROP_Y0+1][CROP_X0]     = 16'h07E0;
      frame[CROP_Y0+1][CROP_X0+1]   = 16'h001F;
      vsync_pulse();
      d0 = done_seen;
      stream(1'b1, NROWS, 0, 1'b0);
      repeat (4) @(negedge clk);
      chk("block_done_count", done_seen - d0, 1);

      full_frame(2, "outside_crop");
      for (int i = 0; i < 3; i++) full_frame(0, "random");

      // abort at output row 2; the pixel carrying vsync would complete block (2,2)
      fill(0);
      vsync_pulse();
      d0 = done_seen;
      v0 = valid_seen;
      stream(1'b1, CROP_Y0 + 5, CROP_X0 + 5, 1'b1);
      vsync_pulse();
      chk("abort_no_done", done_seen - d0, 0);
      chk("abort_valid_count", valid_seen - v0, 2 * OUT_W + 2);
      d0 = done_seen;
      fill(0);
      stream(1'b1, NROWS, 0, 1'b0);
      repeat (4) @(negedge clk);
      chk("after_abort_done", done_seen - d0, 1);

      // reset mid-frame, then pixels without vsync produce nothing
      fill(0);
      vsync_pulse();
      stream(1'b1, CROP_Y0 + 3, 0, 1'b0);
      do_reset();
      fill(0);
      v0 = valid_seen;
      stream(1'b0, NROWS, 0, 1'b0);
      chk("post_reset_silent", valid_seen - v0, 0);
      full_frame(0, "post_reset");

      full_frame(3, "red");

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_downsampler.md
Name: frame_downsampler

Overview:
- Sits directly downstream of the camera capture stage, in the i_pclk domain.
- Takes the captured RGB565 pixel stream with its x/y indices and crops a 2*OUT_W x 2*OUT_H window.
- Reduces the window 2x2 by box averaging and emits 8-bit RGB pixels with a linear write address for the CNN input frame buffer.
- Frame framing is controlled by a small FSM keyed on camera vsync.

Parameters:
- CROP_X0, 96: first input column of the crop window.
- CROP_Y0, 16: first input row of the crop window.
- OUT_W, 224: output width. Line buffer depth. Crop width is 2*OUT_W.
- OUT_H, 224: output height. Crop height is 2*OUT_H.
- ADDR_W, 16: output address width. Must satisfy 2^ADDR_W >= OUT_W*OUT_H.

Ports:
- i_pclk  in  1  clock.
- i_reset  in  1  synchronous, active-low reset.
- i_vsync  in  1  camera vsync; high = frame boundary.
- i_pixelIn  in  16  RGB565 pixel, {R[4:0],G[5:0],B[4:0]}.
- i_pixelValid  in  1  one-cycle strobe; i_pixelIn is a complete pixel.
- i_xIndex  in  10  already incremented on the strobe cycle; pixel column = i_xIndex-1.
- i_yIndex  in  10  pixel row.
- o_valid  out  1  one-cycle strobe; output pixel valid.
- o_r / o_g / o_b  out  8 each  averaged colour channels.
- o_addr  out  ADDR_W  oy*OUT_W+ox.
- o_frameDone  out  1  pulse on the final output pixel of a frame.
- o_busy  out  1  high in ACTIVE state.

Behaviour:
- Reset (i_reset==0 at posedge): all outputs 0, FSM=WAIT_SYNC, pair/row state cleared. Line buffer contents are don't-care.
- FSM states:
  - WAIT_SYNC: ignore pixels; i_vsync=1 -> IN_SYNC.
  - IN_SYNC: i_vsync=0 -> ACTIVE.
  - ACTIVE: process pixels. Final output pixel -> DONE. i_vsync=1 -> IN_SYNC (frame aborted, no o_frameDone).
  - DONE: ignore pixels; i_vsync=1 -> IN_SYNC.
- A reset mid-frame therefore discards the remainder of that frame; output resumes on the next full frame.
- Crop test: cx = (i_xIndex-1)-CROP_X0, cy = i_yIndex-CROP_Y0. A pixel is used only if 0<=cx<2*OUT_W and 0<=cy<2*OUT_H; otherwise it is ignored.
- Channel expansion: R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}.
- Horizontal pairing:
  - Even cx: hold the expanded pixel.
  - Odd cx: hsum = held + current, 9 bits per channel, 27 bits total.
- Line buffer: OUT_W x 27-bit, single-port, synchronous read, index cx>>1.
  - Even cy: on odd cx, write hsum to LB[cx>>1].
  - Odd cy: on even cx, issue read of LB[cx>>1]; on odd cx, vsum = LB data + hsum, 10 bits per channel.
- Output: o_r = vsum_r[9:2] (floor divide by 4), same for g and b.
- o_addr = (cy>>1)*OUT_W + (cx>>1).
- Latency: o_valid asserts exactly 1 cycle after the odd-cx/odd-cy input strobe. Outputs hold their values until the next o_valid.
- o_frameDone=1 in the same cycle as o_valid for ox=OUT_W-1, oy=OUT_H-1.
- i_vsync=1 while in ACTIVE clears the held pixel. No o_valid is produced for a half-complete 2x2 block.
- i_vsync and i_pixelValid high together: vsync wins and the pixel is dropped.
- Minimum input pixel spacing is 2 cycles; back-to-back strobes are not supported.

Optional Feature:
- Macro: FRAME_DOWNSAMPLER_GRAY_EN.
- Defined: adds output port o_gray[7:0] = (77*o_r + 150*o_g + 29*o_b) >> 8.
  - Computed from the averaged channels before the output register.
  - Registered with the same latency and strobe as o_r. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then a frame with every in-crop pixel 16'hFFFF, after vsync pulse -> 50176 o_valid strobes, each o_r=o_g=o_b=8'hFF; o_addr runs 0..50175; single o_frameDone on addr 50175.
- Reset, then block (0,0) inputs F800, 0000, 07E0, 001F (even/odd cx, even/odd cy) -> o_r=8'h3F, o_g=8'h3F, o_b=8'h3F at addr 0, 1 cycle after the 4th strobe.
- Pixels outside the crop window, e.g. column 95 or row 464 set to FFFF with the rest 0000 -> all outputs 0; no extra o_valid strobes.
- Reset, then i_vsync asserted mid-frame at output row 100 -> no o_frameDone; next frame restarts at addr 0 and completes normally.
- i_reset low mid-frame, released, then pixels without vsync -> no o_valid until the next vsync high->low edge.
- FRAME_DOWNSAMPLER_GRAY_EN defined, after reset and a vsync pulse, all in-crop pixels F800 -> o_r=FF, o_gray=8'h4C.
